// File: rtl/tpu_host_seq_if.sv
// Operand and result streams between the host sequencer and its bus-side peer.
// The sequencer uses the slave modport. The bus adapter, or a testbench, uses the master modport.
interface tpu_host_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_index;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index
    );
endinterface

// File: rtl/tpu_host_seq.sv
// Host-side sequencer for the Mini TPU.
// It loads 32 operand bytes (A, then B) as LOAD words and holds COMPUTE while the array fills and drains.
// It then reads the 16 results back one at a time with OUTPUT words and streams them out.
module tpu_host_seq #(
    parameter int COMPUTE_CYCLES = 10,
    parameter int RESULT_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] instruction,
    input  logic [7:0]  result,
    tpu_host_seq_if.slave bus
);

    localparam int CCW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam logic [CCW-1:0] CC_LAST = CCW'(COMPUTE_CYCLES - 1);
    localparam logic [1:0]     WC_LAST = 2'(RESULT_LATENCY - 1);

    localparam logic [15:0] NOP_WORD     = 16'h0000;
    localparam logic [15:0] COMPUTE_WORD = 16'h8000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMP,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_HOLD,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     lc_q, lc_d;
    logic [3:0]     ri_q, ri_d;
    logic [CCW-1:0] cc_q, cc_d;
    logic [1:0]     wc_q, wc_d;
    logic [15:0]    instr_q, instr_d;
    logic           in_ready_q;
    logic           busy_q;
    logic           done_q;
    logic           out_valid_q;
    logic [7:0]     out_data_q;
    logic [3:0]     out_index_q;
    logic           capture;
    logic           in_hs;
    logic           out_hs;

    assign in_hs  = bus.in_valid & in_ready_q;
    assign out_hs = out_valid_q & bus.out_ready;

    // Next-state, counter and instruction-word selection; defaults first
    always_comb begin
        state_d = state_q;
        lc_d    = lc_q;
        ri_d    = ri_q;
        cc_d    = cc_q;
        wc_d    = wc_q;
        instr_d = NOP_WORD;
        capture = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    lc_d    = 5'd0;
                end
            end
            S_LOAD: begin
                if (in_hs) begin
                    instr_d = {2'b01, lc_q[4], lc_q[3:2], lc_q[1:0], 1'b0, bus.in_data};
                    lc_d    = lc_q + 5'd1;
                    if (lc_q == 5'd31) begin
                        state_d = S_COMP;
                        cc_d    = '0;
                    end
                end
            end
            S_COMP: begin
                instr_d = COMPUTE_WORD;
                if (cc_q == CC_LAST) begin
                    state_d = S_RD_ISSUE;
                    ri_d    = 4'd0;
                end else begin
                    cc_d = cc_q + 1'b1;
                end
            end
            S_RD_ISSUE: begin
                instr_d = {2'b11, 10'd0, ri_q};
                wc_d    = 2'd0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // The OUTPUT word stays on the bus for RESULT_LATENCY cycles.
                // The result is sampled in the last of those cycles, and NOP goes out from the next one.
                if (wc_q == WC_LAST) begin
                    capture = 1'b1;
                    state_d = S_RD_HOLD;
                end else begin
                    instr_d = {2'b11, 10'd0, ri_q};
                    wc_d    = wc_q + 2'd1;
                end
            end
            S_RD_HOLD: begin
                if (out_hs) begin
                    if (ri_q == 4'd15) begin
                        state_d = S_FIN;
                    end else begin
                        ri_d    = ri_q + 4'd1;
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and every registered output; reset aborts any job in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lc_q        <= 5'd0;
            ri_q        <= 4'd0;
            cc_q        <= '0;
            wc_q        <= 2'd0;
            instr_q     <= NOP_WORD;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_index_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            lc_q       <= lc_d;
            ri_q       <= ri_d;
            cc_q       <= cc_d;
            wc_q       <= wc_d;
            instr_q    <= instr_d;
            in_ready_q <= (state_d == S_LOAD);
            busy_q     <= (state_d != S_IDLE) && (state_d != S_FIN);
            done_q     <= (state_d == S_FIN);
            if (capture) begin
                out_valid_q <= 1'b1;
                out_data_q  <= result;
                out_index_q <= ri_q;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign instruction   = instr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;

endmodule

// File: tb/tb_tpu_host_seq.sv
// Scoreboard bench for tpu_host_seq with a small behavioural TPU attached.
// Stimulus queues the expected instruction words and result beats.
// A negedge monitor pops and compares them whenever the DUT shows a non-NOP word or completes a result handshake.
module tb_tpu_host_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] instruction;
    logic [7:0]  result;

    tpu_host_seq_if bus ();

    tpu_host_seq #(
        .COMPUTE_CYCLES(10),
        .RESULT_LATENCY(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .instruction(instruction),
        .result     (result),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    logic [15:0] exp_instr_q[$];
    logic [11:0] exp_out_q[$];

    logic [7:0] op_a  [16];
    logic [7:0] op_b  [16];
    logic [7:0] exp_c [16];

    int stall_idx  = -1;
    int stall_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural TPU: stores LOAD words and muxes a product element onto result during OUTPUT
    logic [7:0] ma [16];
    logic [7:0] mb [16];
    always @(posedge clk) begin
        if (instruction[15:14] == 2'b01) begin
            if (instruction[13]) mb[instruction[12:9]] <= instruction[7:0];
            else                 ma[instruction[12:9]] <= instruction[7:0];
        end
    end
    always_comb begin
        result = 8'h00;
        if (instruction[15:14] == 2'b11) begin
            for (int k = 0; k < 4; k++) begin
                logic [1:0] kk;
                kk = 2'(k);
                result = result + 8'(16'(ma[{instruction[3:2], kk}]) * 16'(mb[{kk, instruction[1:0]}]));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compares instruction words and result beats against the scoreboard queues.
    // It also checks that a result beat stays stable while out_ready is low.
    initial begin
        logic        prev_v;
        logic        prev_hs;
        logic [11:0] prev_word;
        prev_v = 1'b0; prev_hs = 1'b0; prev_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (instruction != 16'h0000) begin
                    if (exp_instr_q.size() == 0) chk("instr_extra", 32'(instruction), 32'h0);
                    else chk("instr", 32'(instruction), 32'(exp_instr_q.pop_front()));
                end
                if (prev_v && !prev_hs) begin
                    chk("hold_valid", 32'(bus.out_valid), 32'h1);
                    chk("hold_beat", 32'({bus.out_index, bus.out_data}), 32'(prev_word));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_out_q.size() == 0) chk("out_extra", 32'({bus.out_index, bus.out_data}), 32'hFFFF);
                    else chk("out_beat", 32'({bus.out_index, bus.out_data}), 32'(exp_out_q.pop_front()));
                end
                prev_v    = bus.out_valid;
                prev_hs   = bus.out_valid && bus.out_ready;
                prev_word = {bus.out_index, bus.out_data};
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("busy_at_done", 32'(busy), 32'h0);
                end
            end
        end
    end

    // One job. abort_after >= 0 pulls rst_n low for a cycle once that many operands have been accepted.
    task automatic run_job(input bit toggle, input int stall_at, input bit pulse_start,
                           input int abort_after, output int start_cyc);
        bit hs;
        int n;
        int d0;
        bit p1, p2, early_drop;
        logic [4:0] l;
        logic [7:0] dat;
        for (int i = 0; i < 16; i++) exp_out_q.push_back({4'(i), exp_c[i]});
        stall_idx  = stall_at;
        stall_left = 3;
        start_cyc  = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == abort_after) begin
                bus.in_valid = 1'b0;
                rst_n = 1'b0;
                exp_instr_q.delete();
                exp_out_q.delete();
                @(posedge clk); #1;
                chk("abort_reset_outputs",
                    32'({instruction, bus.in_ready, bus.out_valid, bus.out_data, bus.out_index, busy, done}),
                    32'h0);
                rst_n = 1'b1;
                return;
            end
            if (toggle && i > 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            dat = (i < 16) ? op_a[i] : op_b[i-16];
            l   = 5'(i);
            bus.in_valid = 1'b1;
            bus.in_data  = dat;
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 50) begin
                @(negedge clk);
                hs = bus.in_ready;
                if (hs) exp_instr_q.push_back({2'b01, l[4], l[3:2], l[1:0], 1'b0, dat});
                @(posedge clk); #1;
                n++;
            end
            if (!hs) begin
                chk("in_ready_timeout", 32'h0, 32'h1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        for (int i = 0; i < 10; i++) exp_instr_q.push_back(16'h8000);
        for (int j = 0; j < 16; j++) exp_instr_q.push_back({2'b11, 10'd0, 4'(j)});
        // Offer a 33rd byte: it must not be taken
        bus.in_data = 8'hAA;
        @(negedge clk);
        chk("in_ready_after_32", 32'(bus.in_ready), 32'h0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        d0 = done_cnt;
        n  = 0;
        p1 = 1'b0; p2 = 1'b0; early_drop = 1'b0;
        while (done_cnt == d0 && n < 3000) begin
            start = 1'b0;
            if (pulse_start && !p1 && instruction == 16'h8000) begin start = 1'b1; p1 = 1'b1; end
            if (pulse_start && !p2 && bus.out_valid && bus.out_index == 4'd3) begin start = 1'b1; p2 = 1'b1; end
            if (bus.out_valid && int'(bus.out_index) == stall_idx && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (!busy && !done) early_drop = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        bus.out_ready = 1'b1;
        if (done_cnt == d0) chk("done_timeout", 32'h0, 32'h1);
        chk("busy_during_job", 32'(early_drop), 32'h0);
        if (pulse_start) chk("start_pulses_issued", 32'({p1, p2}), 32'h3);
        repeat (20) @(posedge clk);
        #1;
        chk("done_count", 32'(done_cnt - d0), 32'h1);
        chk("busy_after_job", 32'(busy), 32'h0);
        chk("results_left", 32'(exp_out_q.size()), 32'h0);
        chk("instr_left", 32'(exp_instr_q.size()), 32'h0);
    endtask

    task automatic set_ident_seq();
        for (int i = 0; i < 16; i++) begin
            op_a[i]  = (i % 5 == 0) ? 8'd1 : 8'd0;
            op_b[i]  = 8'(i + 1);
            exp_c[i] = 8'(i + 1);      // I x B = B
        end
    endtask

    initial begin
        int sc;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset: nothing moves
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_instruction", 32'(instruction), 32'h0);
        end
        chk("idle_outputs",
            32'({bus.in_ready, bus.out_valid, bus.out_data, bus.out_index, busy, done}), 32'h0);
        @(posedge clk); #1;

        // Identity x (1..16), contiguous operands.
        // The first word is 16'h4001 and the 32nd is 16'h7E10.
        set_ident_seq();
        run_job(1'b0, -1, 1'b0, -1, sc);
        chk("job_length", 32'(done_cyc - sc), 32'd91);   // 32 + 10 + 16*3 + 1

        // Same job with in_valid toggling
        run_job(1'b1, -1, 1'b0, -1, sc);

        // All-16 operands: every sum is 4*256, which wraps to zero. out_ready stalls at index 5.
        for (int i = 0; i < 16; i++) begin
            op_a[i] = 8'd16; op_b[i] = 8'd16; exp_c[i] = 8'h00;
        end
        run_job(1'b0, 5, 1'b0, -1, sc);

        // start pulsed during COMP and RD_HOLD is ignored
        set_ident_seq();
        run_job(1'b0, -1, 1'b1, -1, sc);

        // Abort after 20 operands, then a fresh full job
        run_job(1'b0, -1, 1'b0, 20, sc);
        repeat (3) @(posedge clk);
        #1;
        chk("post_abort_idle", 32'({instruction, bus.in_ready, busy}), 32'h0);
        run_job(1'b0, -1, 1'b0, -1, sc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tpu_host_seq.md
# tpu_host_seq

Host-side sequencer that drives the Mini TPU `instruction` port and collects its `result` port, so the TPU is never hand-programmed. It accepts 32 operand bytes on a valid/ready stream: matrix A then matrix B, each 4x4 row-major. It emits the LOAD, COMPUTE and OUTPUT instruction words, then returns the 16 result bytes on a valid/ready output stream. It sits between the system bus adapter and the `tpu` top.

## Interface
- `COMPUTE_CYCLES`, default 10: number of consecutive cycles COMPUTE is held, covering the 4x4 array fill and drain.
- `RESULT_LATENCY`, default 1: cycles from issuing an OUTPUT word to `result` being valid; range 1..3.
- `clk`  input  1  single clock; all logic is rising-edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `start`  input  1  begins one job; sampled only in IDLE.
- `busy`  output  1  high from the cycle after `start` is accepted until the cycle `done` pulses.
- `done`  output  1  one-cycle pulse after the 16th result handshake.
- `in_valid` / `in_ready` / `in_data`  input / output / input  1/1/8  operand stream.
- `instruction`  output  16  registered TPU instruction word.
- `result`  input  8  TPU result byte.
- `out_valid` / `out_ready`  output / input  1/1  result stream handshake.
- `out_data`  output  8  result byte.
- `out_index`  output  4  result index {row[1:0], col[1:0]}.

## Operation
- Instruction encoding uses `[15:14]` as the opcode.
  - 00: NOP, all other bits 0.
  - 01: LOAD. `[13]` is the matrix (0=A, 1=B), `[12:11]` the line, `[10:9]` the elem, `[7:0]` the data, `[8]`=0.
  - 10: COMPUTE, `[13:0]`=0.
  - 11: OUTPUT. `[3:2]` is the row, `[1:0]` the col, `[13:4]`=0.
- State machine: IDLE -> LOAD -> COMP -> RD_ISSUE -> RD_WAIT -> RD_HOLD -> (RD_ISSUE | FIN) -> IDLE.
- IDLE
  - `in_ready`=0; `instruction`=NOP.
  - `start`=1 moves to LOAD and clears the 5-bit load counter `lc`.
- LOAD
  - `in_ready`=1.
  - Each handshake (`in_valid & in_ready`) registers a LOAD word with matrix=`lc[4]`, line=`lc[3:2]`, elem=`lc[1:0]`, data=`in_data`, then increments `lc`.
  - Cycles without a handshake register NOP.
  - After the handshake with `lc`=31, go to COMP.
- COMP: register COMPUTE for exactly `COMPUTE_CYCLES` cycles, then go to RD_ISSUE with index `ri`=0.
- RD_ISSUE: register OUTPUT with row=`ri[3:2]`, col=`ri[1:0]` for one cycle, then go to RD_WAIT.
- RD_WAIT
  - `instruction` holds the same OUTPUT word (the TPU result mux is combinational on row/col).
  - Wait `RESULT_LATENCY` cycles, counted from the cycle the OUTPUT word first appears on `instruction`.
  - Then capture `result` into `out_data` and `ri` into `out_index`, set `out_valid`=1, and go to RD_HOLD.
- RD_HOLD
  - `instruction` = NOP. `out_valid`, `out_data` and `out_index` are held stable until `out_ready`=1.
  - On the handshake, `out_valid` drops the next cycle.
  - If `ri`=15, go to FIN; otherwise increment `ri` and go to RD_ISSUE.
- FIN: `done`=1 for one cycle, `busy` drops in the same cycle, then IDLE.
- `start` outside IDLE is ignored. There is no queuing.
- No arithmetic is done here. Result bytes are passed through unmodified (the TPU's 8-bit wrap is preserved).

## Timing
- Reset values: `instruction`=16'h0000, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `busy`=0, `done`=0. State=IDLE, `lc`=`ri`=0, all counters cleared.
- Reset mid-operation aborts the job the same edge. No partial results are emitted and the next job starts from `lc`=0.
- `instruction`, `out_*`, `busy`, `done` and `in_ready` are all registered. `in_ready` is a state decode, registered via next-state.
- Operand bytes appear on `instruction` exactly one cycle after their handshake.
- `in_ready` falls in the cycle after the 32nd handshake; a 33rd byte is never accepted.
- The first COMPUTE word appears the cycle after the last LOAD word.
- Minimum job length with no stalls: 32 + `COMPUTE_CYCLES` + 16×(2 + `RESULT_LATENCY`) + 1 cycles from `start` to `done`.
- `out_valid` must not drop without a handshake.

## Test plan
- Reset then idle 5 cycles -> every output at its reset value; `instruction`=0 throughout.
- A=identity, B bytes 1..16, contiguous `in_valid`, `out_ready`=1, defaults:
  - `instruction` shows 16'h4001 first and 16'h7E10 at the 32nd LOAD.
  - Then 10 cycles of 16'h8000.
  - Then OUTPUT words C000..C00F.
  - Outputs are 1..16 with `out_index` 0..15, followed by a single `done` pulse.
- Same job with `in_valid` toggling every other cycle -> exactly 32 LOAD words with the same contents, NOPs in the gaps, identical results.
- A = all 16, B = all 16 -> every result is 8'h00 (4×256 mod 256); `out_ready` stalled 3 cycles on index 5 -> `out_data`/`out_index` held stable, no skipped or duplicated index.
- `start` pulsed during COMP and during RD_HOLD -> ignored; exactly one `done`; `busy` stays high until FIN.
- `rst_n` low for one cycle after the 20th operand -> all outputs reset next edge; a fresh full job then completes with correct results.
